// File: rtl/pci_rr_arbiter.sv
// ----------------------------------------------------------------------------
// pci_rr_arbiter
//   Round-robin PCI bus arbiter. The bus changes hands only between
//   transactions, and there is always one dead (all-zero grant) cycle before
//   a new master is granted. When nobody requests, the grant can stay parked
//   on the last owner. A grant that the master never uses is taken back after
//   TIMEOUT cycles.
//
// Parameters
//   N_REQ    number of bus masters (2..16)
//   TIMEOUT  cycles a granted master may leave frame_n high before the grant
//            is revoked (>= 2)
//   PARK     1: keep gnt on the last owner while idle, 0: drop gnt while idle
//
// Ports
//   clk        bus clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-master request, active-high
//   frame_n    PCI FRAME#, active-low
//   irdy_n     PCI IRDY#, active-low
//   gnt        registered grant, one-hot or zero
//   owner      index of the current or last grantee
//   owner_vld  high while any grant is asserted
//   timeout    one-cycle pulse when an unused grant is revoked
// ----------------------------------------------------------------------------
module pci_rr_arbiter #(
    parameter int N_REQ   = 8,
    parameter int TIMEOUT = 16,
    parameter bit PARK    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     frame_n,
    input  logic                     irdy_n,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     owner_vld,
    output logic                     timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic             has_owner;
    logic             bus_idle;
    logic             any_req;
    logic             found;
    logic [IW-1:0]    winner;
    logic [N_REQ-1:0] win_oh;
    logic [N_REQ-1:0] own_oh;

    assign bus_idle  = frame_n & irdy_n;
    assign any_req   = |req;
    assign owner_vld = |gnt;
    assign win_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    assign own_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << owner;

    // Round-robin search: start just after the last winner and wrap, so the
    // last winner itself has the lowest priority. With ptr reset to N_REQ-1
    // master 0 is first in line after reset.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[IW'((int'(ptr) + k) % N_REQ)]) begin
                found  = 1'b1;
                winner = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // Main arbitration FSM. Every path that hands the bus to a new master
    // first goes through ARB with gnt cleared, which gives the turnaround
    // cycle. In IDLE a non-zero gnt means the bus is parked on owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            owner     <= '0;
            timeout   <= 1'b0;
            ptr       <= IW'(N_REQ - 1);
            cnt       <= '0;
            has_owner <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (owner_vld && !frame_n) begin
                        state <= ST_BUSY;
                    end else if (any_req && bus_idle) begin
                        state <= ST_ARB;
                        gnt   <= '0;
                    end
                end
                ST_ARB: begin
                    if (found) begin
                        state     <= ST_GRANT;
                        gnt       <= win_oh;
                        owner     <= winner;
                        ptr       <= winner;
                        cnt       <= '0;
                        has_owner <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        gnt   <= (PARK && has_owner) ? own_oh : '0;
                    end
                end
                ST_GRANT: begin
                    // A transaction start wins over a timeout on the same edge.
                    if (!frame_n) begin
                        state <= ST_BUSY;
                    end else if (!req[owner]) begin
                        state <= ST_ARB;
                        gnt   <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state   <= ST_ARB;
                        gnt     <= '0;
                        timeout <= 1'b1;
                    end else if (cnt != CW'(TIMEOUT)) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BUSY: begin
                    if (bus_idle) begin
                        state <= ST_ARB;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_pci_rr_arbiter
//   Directed bench for pci_rr_arbiter. Two instances share the stimulus: one
//   with parking enabled and one with parking disabled. A cycle table covers
//   no-pre-emption, pointer wrap, parking and early release; hand-written
//   sequences cover reset, full rotation and the unused-grant timeout.
// ----------------------------------------------------------------------------
module tb_pci_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       frame_n;
    logic       irdy_n;
    logic [7:0] gnt;
    logic [2:0] owner;
    logic       owner_vld;
    logic       timeout;
    logic [7:0] gnt_np;
    logic [2:0] owner_np;
    logic       owner_vld_np;
    logic       timeout_np;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] req;
        logic       frame_n;
        logic       irdy_n;
        logic [7:0] gnt;
        logic [7:0] gnt_np;
        logic [2:0] owner;
    } vec_t;

    vec_t vecs[22];

    pci_rr_arbiter #(.N_REQ(8), .TIMEOUT(16), .PARK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .frame_n(frame_n),
        .irdy_n(irdy_n), .gnt(gnt), .owner(owner),
        .owner_vld(owner_vld), .timeout(timeout)
    );

    pci_rr_arbiter #(.N_REQ(8), .TIMEOUT(16), .PARK(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .req(req), .frame_n(frame_n),
        .irdy_n(irdy_n), .gnt(gnt_np), .owner(owner_np),
        .owner_vld(owner_vld_np), .timeout(timeout_np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        req     = v.req;
        frame_n = v.frame_n;
        irdy_n  = v.irdy_n;
        tick();
    endtask

    task automatic wait_grant(output int zeros, output logic ok);
        zeros = 0;
        ok    = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            tick();
            if (gnt != 0) ok = 1'b1;
            else zeros++;
        end
    endtask

    // Continuous invariants on the parked instance: one-hot grant, owner_vld
    // consistent with gnt, and no direct hand-over between two masters.
    logic [7:0] prev_gnt;
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("onehot", 32'($countones(gnt) <= 1), 32'd1);
            check_output("owner_vld", 32'(owner_vld), 32'(|gnt));
            if (prev_gnt != 0 && gnt != 0)
                check_output("handover", 32'(gnt), 32'(prev_gnt));
            prev_gnt <= gnt;
        end else begin
            prev_gnt <= '0;
        end
    end

    initial begin
        int   zeros;
        logic ok;
        int   pulses;

        checks   = 0;
        failures = 0;

        // Cycle table: each row sets inputs, takes one clock, then compares.
        vecs[0]  = '{8'h01, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0};
        vecs[1]  = '{8'h81, 1'b1, 1'b1, 8'h01, 8'h01, 3'd0};
        vecs[2]  = '{8'h81, 1'b0, 1'b1, 8'h01, 8'h01, 3'd0};
        vecs[3]  = '{8'h81, 1'b0, 1'b1, 8'h01, 8'h01, 3'd0};
        vecs[4]  = '{8'h81, 1'b0, 1'b0, 8'h01, 8'h01, 3'd0};
        vecs[5]  = '{8'h81, 1'b1, 1'b0, 8'h01, 8'h01, 3'd0};
        vecs[6]  = '{8'h81, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0};
        vecs[7]  = '{8'h81, 1'b1, 1'b1, 8'h80, 8'h80, 3'd7};
        vecs[8]  = '{8'h81, 1'b0, 1'b1, 8'h80, 8'h80, 3'd7};
        vecs[9]  = '{8'h81, 1'b1, 1'b1, 8'h00, 8'h00, 3'd7};
        vecs[10] = '{8'h81, 1'b1, 1'b1, 8'h01, 8'h01, 3'd0};
        vecs[11] = '{8'h01, 1'b0, 1'b1, 8'h01, 8'h01, 3'd0};
        vecs[12] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0};
        vecs[13] = '{8'h00, 1'b1, 1'b1, 8'h01, 8'h00, 3'd0};
        vecs[14] = '{8'h00, 1'b1, 1'b1, 8'h01, 8'h00, 3'd0};
        vecs[15] = '{8'h00, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0};
        vecs[16] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0};
        vecs[17] = '{8'h00, 1'b1, 1'b1, 8'h01, 8'h00, 3'd0};
        vecs[18] = '{8'h02, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0};
        vecs[19] = '{8'h02, 1'b1, 1'b1, 8'h02, 8'h02, 3'd1};
        vecs[20] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 3'd1};
        vecs[21] = '{8'h00, 1'b1, 1'b1, 8'h02, 8'h00, 3'd1};

        // Reset state
        do_reset();
        #1;
        check_output("reset gnt", 32'(gnt), 32'h0);
        check_output("reset owner", 32'(owner), 32'h0);
        check_output("reset owner_vld", 32'(owner_vld), 32'h0);
        check_output("reset timeout", 32'(timeout), 32'h0);

        // Table: no pre-emption, pointer wrap, parking, early release
        for (int i = 0; i < 22; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check_output($sformatf("vec%0d gnt_np", i), 32'(gnt_np), 32'(vecs[i].gnt_np));
            check_output($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].owner));
            check_output($sformatf("vec%0d timeout", i), 32'(timeout), 32'h0);
        end

        // Asynchronous reset in the middle of a transaction
        do_reset();
        req = 8'h04;
        tick();
        tick();
        check_output("t1 grant", 32'(gnt), 32'h04);
        frame_n = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t1 async gnt", 32'(gnt), 32'h0);
        check_output("t1 async owner_vld", 32'(owner_vld), 32'h0);
        check_output("t1 async owner", 32'(owner), 32'h0);

        // Rotation with every master requesting
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_grant(zeros, ok);
            check_output($sformatf("t2 wait %0d", i), 32'(ok), 32'h1);
            check_output($sformatf("t2 gnt %0d", i), 32'(gnt), 32'(8'h01 << (i % 8)));
            check_output($sformatf("t2 owner %0d", i), 32'(owner), 32'(i % 8));
            check_output($sformatf("t2 gap %0d", i), 32'(zeros), 32'd1);
            frame_n = 1'b0;
            tick();
            tick();
            tick();
            frame_n = 1'b1;
        end

        // Unused grant timeout
        do_reset();
        req = 8'h06;
        tick();
        tick();
        check_output("t3 first gnt", 32'(gnt), 32'h02);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (timeout) pulses++;
            check_output($sformatf("t3 hold %0d", c), 32'(gnt), 32'h02);
        end
        tick();
        if (timeout) pulses++;
        check_output("t3 revoke gnt", 32'(gnt), 32'h00);
        check_output("t3 pulse", 32'(timeout), 32'h1);
        tick();
        if (timeout) pulses++;
        check_output("t3 next gnt", 32'(gnt), 32'h04);
        check_output("t3 pulse count", 32'(pulses), 32'd1);

        // Frame start on the would-be timeout edge counts as a transaction
        for (int c = 0; c < 15; c++) tick();
        frame_n = 1'b0;
        tick();
        check_output("t3 start at limit gnt", 32'(gnt), 32'h04);
        check_output("t3 start at limit timeout", 32'(timeout), 32'h0);
        frame_n = 1'b1;
        tick();
        check_output("t3 after busy gnt", 32'(gnt), 32'h00);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

endmodule
